// File: rtl/disp_pkg.sv
// Shared types, constants and digit-search helpers for the display scan path.
package disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = 3;
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;

    typedef logic [3:0] digit_t;
    typedef digit_t [NUM_DIGITS-1:0] digit_arr_t;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_t;

    function automatic logic [SEL_W-1:0] lowest_en(input logic [NUM_DIGITS-1:0] en);
        lowest_en = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (en[i]) lowest_en = i[SEL_W-1:0];
        end
    endfunction

    // Returns {found, index} of the lowest enabled digit strictly above cur.
    function automatic logic [SEL_W:0] next_en_above(input logic [NUM_DIGITS-1:0] en,
                                                     input logic [SEL_W-1:0]      cur);
        next_en_above = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (en[i] && (i > int'(cur))) next_en_above = {1'b1, i[SEL_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Refresh prescaler: counts 0..DIV-1 and flags the last count as the scan tick.
module scan_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller with frame-synchronous shadow loading.
// Optional anode blanking after each tick is enabled with `define SCAN_BLANK_EN.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | no digit lit (after reset, or last tick saw digit_en == 0)
//  ST_SCAN | a digit is selected and may be lit
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  digit_arr_t            nums_in,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic                  load_req,
    output logic                  load_ack,
    output logic [SEL_W-1:0]      sel,
    output digit_t                digit_val,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic                  frame_start
);

    if (REFRESH_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
        $error("display_scan_ctrl: need REFRESH_DIV >= 2 and 1 <= BLANK_CYCLES < REFRESH_DIV");
    end

    scan_state_t           state_q, state_d;
    logic                  tick;
    logic [SEL_W-1:0]      sel_d, first_en, above_idx;
    logic                  above_found;
    logic                  boundary, frame_d, load_d, lit_d, blanking;
    digit_arr_t            shadow_q, shadow_d;
    digit_t                digit_val_d;
    logic [NUM_DIGITS-1:0] anode_d;

    scan_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign first_en                 = lowest_en(digit_en);
    assign {above_found, above_idx} = next_en_above(digit_en, sel);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // A frame boundary is any wrap to the lowest enabled digit, or any tick with nothing enabled.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel;
        frame_d  = 1'b0;
        boundary = 1'b0;
        if (tick) begin
            if (digit_en == '0) begin
                state_d  = ST_IDLE;
                boundary = 1'b1;
            end else if (state_q == ST_IDLE || !above_found) begin
                state_d  = ST_SCAN;
                sel_d    = first_en;
                frame_d  = 1'b1;
                boundary = 1'b1;
            end else begin
                sel_d = above_idx;
            end
        end
    end

`ifdef SCAN_BLANK_EN
    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    logic [BLANK_W-1:0] blank_q;

    // The tick cycle itself accounts for the first blank cycle, so load one less.
    always_ff @(posedge clk) begin
        if (rst)
            blank_q <= '0;
        else if (tick)
            blank_q <= BLANK_W'(BLANK_CYCLES - 1);
        else if (blank_q != '0)
            blank_q <= blank_q - BLANK_W'(1);
    end

    assign blanking = tick || (blank_q != '0);
`else
    assign blanking = 1'b0;
`endif

    // New shadow contents feed digit_val directly so the first frame already shows them.
    always_comb begin
        load_d      = boundary & load_req;
        shadow_d    = load_d ? nums_in : shadow_q;
        digit_val_d = shadow_d[sel_d];
        lit_d       = (state_d == ST_SCAN) && digit_en[sel_d] && !blanking;
        anode_d     = lit_d ? ~(NUM_DIGITS'(1) << sel_d) : ANODES_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel         <= '0;
            shadow_q    <= '0;
            digit_val   <= '0;
            anode_n     <= ANODES_OFF;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            sel         <= sel_d;
            shadow_q    <= shadow_d;
            digit_val   <= digit_val_d;
            anode_n     <= anode_d;
            load_ack    <= load_d;
            frame_start <= frame_d;
        end
    end

endmodule
